// File: rtl/interfaz_adc_spi.sv
// Serial-ADC capture stage: paces the sample rate, reads one 16-clock SPI frame per sample,
// and converts the 12-bit unsigned code into the signed fixed-point Uk word for the filter.
module interfaz_adc_spi #(
    parameter int N            = 25,
    parameter int FRAC         = 15,
    parameter int DIV_SCLK     = 4,
    parameter int DIV_MUESTREO = 5000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         SDATA,
    output logic         SCLK,
    output logic         CS_n,
    output logic [N-1:0] Uk,
    output logic [11:0]  Dato_Crudo,
    output logic         Bandera_ADC,
    output logic         Error_Overrun,
    output logic         Error_Trama
);

    localparam int CW = $clog2(DIV_MUESTREO);
    localparam int DW = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } estado_t;

    // Offset-binary code to signed full-scale +-1.0; the left shift keeps it exact.
    function automatic logic [N-1:0] a_punto_fijo(input logic [11:0] codigo);
        logic signed [12:0] diff;
        logic signed [N-1:0] ext;
        diff = $signed({1'b0, codigo}) - 13'sd2048;
        ext  = N'(diff);
        return ext << (FRAC - 11);
    endfunction

    estado_t        state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  div_q, div_d;
    logic [3:0]     bit_q, bit_d;
    logic           phase_q, phase_d;
    logic [15:0]    shift_q, shift_d;
    logic           sclk_q, sclk_d;
    logic           cs_n_q, cs_n_d;
    logic [N-1:0]   uk_q, uk_d;
    logic [11:0]    crudo_q, crudo_d;
    logic           bandera_q, bandera_d;
    logic           overrun_q, overrun_d;
    logic           trama_q, trama_d;
    logic           tick_s;
    logic           div_fin_s;

    // Next-state logic: sample counter, frame FSM, shift register and output loads.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        uk_d      = uk_q;
        crudo_d   = crudo_q;
        overrun_d = overrun_q;
        trama_d   = trama_q;

        tick_s    = (cnt_q == CW'(DIV_MUESTREO - 1));
        div_fin_s = (div_q == DW'(DIV_SCLK - 1));

        if (tick_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tick_s) begin
                    state_d = S_SETUP;
                    div_d   = {DW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (div_fin_s) begin
                    state_d = S_SHIFT;
                    div_d   = {DW{1'b0}};
                    phase_d = 1'b0;
                    bit_d   = 4'd0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_SHIFT: begin
                if (!div_fin_s) begin
                    div_d = div_q + DW'(1);
                end else if (!phase_q) begin
                    // End of the low half: this edge raises SCLK, so sample now.
                    div_d   = {DW{1'b0}};
                    phase_d = 1'b1;
                    shift_d = {shift_q[14:0], SDATA};
                end else if (bit_q == 4'd15) begin
                    div_d   = {DW{1'b0}};
                    state_d = S_FIN;
                end else begin
                    div_d   = {DW{1'b0}};
                    phase_d = 1'b0;
                    bit_d   = bit_q + 4'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tick_s && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        // Outputs are registered from the next state so the pins never glitch.
        sclk_d    = !((state_d == S_SHIFT) && !phase_d);
        cs_n_d    = (state_d == S_IDLE) || (state_d == S_FIN);
        bandera_d = (state_d == S_FIN);

        if (state_d == S_FIN) begin
            crudo_d = shift_q[11:0];
            uk_d    = a_punto_fijo(shift_q[11:0]);
            trama_d = trama_q | (shift_q[15:12] != 4'd0);
        end else begin
            crudo_d = crudo_q;
            uk_d    = uk_q;
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            div_q     <= {DW{1'b0}};
            bit_q     <= 4'd0;
            phase_q   <= 1'b0;
            shift_q   <= 16'd0;
            sclk_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            uk_q      <= {N{1'b0}};
            crudo_q   <= 12'd0;
            bandera_q <= 1'b0;
            overrun_q <= 1'b0;
            trama_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            uk_q      <= uk_d;
            crudo_q   <= crudo_d;
            bandera_q <= bandera_d;
            overrun_q <= overrun_d;
            trama_q   <= trama_d;
        end
    end

    assign SCLK          = sclk_q;
    assign CS_n          = cs_n_q;
    assign Uk            = uk_q;
    assign Dato_Crudo    = crudo_q;
    assign Bandera_ADC   = bandera_q;
    assign Error_Overrun = overrun_q;
    assign Error_Trama   = trama_q;

endmodule

// File: tb/tb_interfaz_adc_spi.sv
// Scoreboard bench for interfaz_adc_spi: an ADC model serves queued frames, a monitor checks
// each strobe against queued expectations plus SPI waveform timing.
module tb_interfaz_adc_spi;
    localparam int N = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, sdata_a, sclk_a, cs_a, band_a, ovr_a, tra_a;
    logic [N-1:0]  uk_a;
    logic [11:0]   crudo_a;
    logic          rst_b, sdata_b, sclk_b, cs_b, band_b, ovr_b, tra_b;
    logic [N-1:0]  uk_b;
    logic [11:0]   crudo_b;

    interfaz_adc_spi #(.N(25), .FRAC(15), .DIV_SCLK(4), .DIV_MUESTREO(5000)) dut_a (
        .Clk(clk), .Reset(rst_a), .SDATA(sdata_a), .SCLK(sclk_a), .CS_n(cs_a),
        .Uk(uk_a), .Dato_Crudo(crudo_a), .Bandera_ADC(band_a),
        .Error_Overrun(ovr_a), .Error_Trama(tra_a));

    interfaz_adc_spi #(.N(25), .FRAC(15), .DIV_SCLK(4), .DIV_MUESTREO(100)) dut_b (
        .Clk(clk), .Reset(rst_b), .SDATA(sdata_b), .SCLK(sclk_b), .CS_n(cs_b),
        .Uk(uk_b), .Dato_Crudo(crudo_b), .Bandera_ADC(band_b),
        .Error_Overrun(ovr_b), .Error_Trama(tra_b));

    typedef struct {
        logic [N-1:0] uk;
        logic [11:0]  raw;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] adc_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int edges_cs_high = 0;
    int frames_b = 0;
    bit started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [15:0] word, input bit expect_out,
                         input logic [N-1:0] uk, input logic [11:0] raw);
        exp_t e;
        adc_q.push_back(word);
        if (expect_out) begin
            e.uk  = uk;
            e.raw = raw;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (strobe_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: got %0d strobes, expected %0d", strobe_cnt, target);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs_n"}, cs_a, 1'b1);
        check({tag, "_sclk"}, sclk_a, 1'b1);
        check({tag, "_uk"}, uk_a, 32'h0);
        check({tag, "_raw"}, crudo_a, 32'h0);
        check({tag, "_strobe"}, band_a, 1'b0);
        check({tag, "_overrun"}, ovr_a, 1'b0);
        check({tag, "_trama"}, tra_a, 1'b0);
    endtask

    // ADC model: word loaded on CS_n fall, next bit presented on each SCLK falling edge.
    initial begin
        logic [15:0] word;
        int k;
        word = 16'h0000;
        k = 16;
        sdata_a = 1'b0;
        forever begin
            @(negedge cs_a or negedge sclk_a);
            if (sclk_a === 1'b1) begin
                word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
                k = 0;
            end else if (cs_a === 1'b0 && k < 16) begin
                sdata_a = word[15-k];
                k++;
            end
        end
    end

    // Monitor for DUT A: scoreboard pops on strobe, plus SCLK/CS_n waveform timing.
    initial begin
        logic prev_cs, prev_sclk, prev_rst, prev_band;
        int run, pulses, rel_cyc, cs_fall_cyc, prev_strobe;
        bit skip, have_prev, first_cs, first_strobe;
        exp_t e;
        prev_cs = 1'b1; prev_sclk = 1'b1; prev_rst = 1'b1; prev_band = 1'b0;
        run = 0; pulses = 0; rel_cyc = 0; cs_fall_cyc = 0; prev_strobe = 0;
        skip = 1'b0; have_prev = 1'b0; first_cs = 1'b0; first_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (started) begin
                if (rst_a) begin
                    have_prev = 1'b0;
                    skip = 1'b1;
                end else if (prev_rst) begin
                    rel_cyc = cyc;
                    first_cs = 1'b1;
                    first_strobe = 1'b1;
                end
                if (prev_cs && !cs_a) begin
                    cs_fall_cyc = cyc;
                    pulses = 0;
                    run = 1;
                    skip = 1'b0;
                    if (first_cs) begin
                        check("cs_fall_after_reset", cyc - rel_cyc, 5000);
                        first_cs = 1'b0;
                    end
                end else if (!prev_cs && !cs_a) begin
                    if (sclk_a != prev_sclk) begin
                        check("sclk_half_len", run, 4);
                        run = 1;
                        if (sclk_a) pulses++;
                    end else begin
                        run++;
                    end
                end
                if (prev_cs && cs_a && sclk_a != prev_sclk) edges_cs_high++;
                if (!prev_cs && cs_a && !skip) check("sclk_pulses", pulses, 16);
                if (band_a) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got strobe, expected none (cycle %0d)", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check("uk", uk_a, e.uk);
                        check("dato_crudo", crudo_a, e.raw);
                    end
                    check("strobe_latency", cyc - cs_fall_cyc, 132);
                    check("strobe_width", prev_band, 1'b0);
                    if (have_prev) check("strobe_spacing", cyc - prev_strobe, 5000);
                    if (first_strobe) begin
                        check("first_strobe", cyc - rel_cyc, 5132);
                        first_strobe = 1'b0;
                    end
                    have_prev = 1'b1;
                    prev_strobe = cyc;
                    strobe_cnt++;
                end
            end
            prev_cs = cs_a; prev_sclk = sclk_a; prev_rst = rst_a; prev_band = band_a;
        end
    end

    // Monitor for DUT B (overrunning sample rate): every frame must still be complete.
    initial begin
        logic prev_cs;
        int pulses;
        logic prev_sclk;
        prev_cs = 1'b1; prev_sclk = 1'b1; pulses = 0;
        forever begin
            @(negedge clk);
            if (started && !rst_b) begin
                if (prev_cs && !cs_b) pulses = 0;
                if (!cs_b && !prev_sclk && sclk_b) pulses++;
                if (!prev_cs && cs_b) begin
                    check("b_sclk_pulses", pulses, 16);
                    frames_b++;
                end
                if (band_b) check("b_uk", uk_b, 32'h1FF8000);
            end
            prev_cs = cs_b; prev_sclk = sclk_b;
        end
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        sdata_b = 1'b0;
        issue(16'h0FFF, 1'b1, 25'h0007FF0, 12'hFFF);
        issue(16'h0000, 1'b1, 25'h1FF8000, 12'h000);
        issue(16'h0800, 1'b1, 25'h0000000, 12'h800);
        issue(16'h07FF, 1'b1, 25'h1FFFFF0, 12'h7FF);
        issue(16'hA123, 1'b1, 25'h1FF9230, 12'h123);
        issue(16'h0FFF, 1'b1, 25'h0007FF0, 12'hFFF);
        repeat (3) @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        repeat (150) @(negedge clk);
        check("b_overrun_before_2nd_tick", ovr_b, 1'b0);
        repeat (100) @(negedge clk);
        check("b_overrun_after_2nd_tick", ovr_b, 1'b1);
        check("b_trama", tra_b, 1'b0);

        wait_strobes(4, 21000);
        @(negedge clk);
        check("overrun_clean", ovr_a, 1'b0);
        check("trama_clean", tra_a, 1'b0);
        wait_strobes(5, 5200);
        @(negedge clk);
        check("trama_set", tra_a, 1'b1);
        wait_strobes(6, 5200);
        @(negedge clk);
        check("trama_sticky", tra_a, 1'b1);
        check("overrun_still_clear", ovr_a, 1'b0);

        // Abort a frame in the low half of its 8th SCLK period.
        issue(16'h0555, 1'b0, 25'h0, 12'h0);
        begin
            int n = 0;
            bit seen = 1'b0;
            while (!seen && n < 5200) begin
                @(posedge clk);
                #1;
                n++;
                if (cs_a == 1'b0) seen = 1'b1;
            end
            check("abort_frame_started", seen, 1'b1);
        end
        repeat (62) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");

        issue(16'h0ABC, 1'b1, 25'h0002BC0, 12'hABC);
        wait_strobes(7, 5400);
        repeat (5) @(negedge clk);
        check("uk_hold", uk_a, 32'h0002BC0);
        check("pending_expectations", sb_q.size(), 0);
        check("sclk_edges_cs_high", edges_cs_high, 0);
        check("b_frames_seen", frames_b > 100, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
